// File: rtl/lcd_bus_reader_pkg.sv
// ---------------------------------------------------------------------------
// lcd_bus_reader_pkg
//   Shared definitions for the HD44780 character-LCD read engine: FSM state
//   encodings (4-bit, legacy-compatible localparams), default bus timing in
//   50 MHz clock cycles, counter widths and a small helper that decodes which
//   states hold the LCD in read mode (RW=1).
//   No ports (package).
// ---------------------------------------------------------------------------
package lcd_bus_reader_pkg;

  // FSM state encodings shared with the LCD writer's encoding space
  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_REL   = 4'd1;
  localparam logic [3:0] ST_SETUP = 4'd2;
  localparam logic [3:0] ST_EH1   = 4'd3;
  localparam logic [3:0] ST_GAP1  = 4'd4;
  localparam logic [3:0] ST_EH2   = 4'd5;
  localparam logic [3:0] ST_EVAL  = 4'd6;
  localparam logic [3:0] ST_GAP2  = 4'd7;
  localparam logic [3:0] ST_HOLD  = 4'd8;
  localparam logic [3:0] ST_TURN  = 4'd9;

  // Default timing in SYS_CLK_50M cycles
  localparam int T_SETUP_DEF  = 2;
  localparam int T_EH_DEF     = 12;
  localparam int T_GAP_DEF    = 50;
  localparam int T_TURN_DEF   = 2;
  localparam int POLL_MAX_DEF = 100000;

  // Counter widths: phase timer must cover the longest phase (T_GAP)
  localparam int PHASE_W    = 6;
  localparam int POLL_CNT_W = 17;

  // True in every state where the LCD must see RW=1
  function automatic logic rw_active(input logic [3:0] st);
    return (st == ST_SETUP) || (st == ST_EH1) || (st == ST_GAP1) ||
           (st == ST_EH2) || (st == ST_EVAL) || (st == ST_GAP2) ||
           (st == ST_HOLD);
  endfunction

endpackage

// File: rtl/lcd_bus_reader.sv
// ---------------------------------------------------------------------------
// lcd_bus_reader
//   HD44780 4-bit read engine. Runs RW=1 bus cycles to fetch either the busy
//   flag + address counter (RS=0) or a DDRAM/CGRAM byte (RS=1). In poll mode
//   it repeats RS=0 reads until BF=0 or the poll budget runs out.
//   lcd_drv_en gates the top-level tri-state buffer on LCD_DATA[7:4].
// Ports
//   SYS_CLK_50M  in   50 MHz system clock
//   SYS_RST      in   asynchronous active-high reset
//   rd_req       in   pulse: start a single read (accepted when busy=0)
//   rd_rs        in   RS for the single read, sampled with rd_req
//   poll_req     in   pulse: start busy-flag polling (wins over rd_req)
//   busy         out  high from accept until the done cycle
//   done         out  1-cycle pulse at the end of a read or poll
//   rd_data      out  last byte read {upper,lower}
//   bf, ac       out  busy flag / address counter of the last RS=0 read
//   timeout      out  poll gave up after POLL_MAX cycles
//   LCD_RS/RW/E  out  LCD control lines
//   LCD_DATA_IN  in   LCD_DATA[7:4] as seen by the input buffer
//   lcd_drv_en   out  1 = FPGA may drive LCD_DATA
// ---------------------------------------------------------------------------
module lcd_bus_reader
  import lcd_bus_reader_pkg::*;
#(
  parameter int T_SETUP  = T_SETUP_DEF,
  parameter int T_EH     = T_EH_DEF,
  parameter int T_GAP    = T_GAP_DEF,
  parameter int T_TURN   = T_TURN_DEF,
  parameter int POLL_MAX = POLL_MAX_DEF
) (
  input  logic       SYS_CLK_50M,
  input  logic       SYS_RST,
  input  logic       rd_req,
  input  logic       rd_rs,
  input  logic       poll_req,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       bf,
  output logic [6:0] ac,
  output logic       timeout,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  input  logic [3:0] LCD_DATA_IN,
  output logic       lcd_drv_en
);

  localparam logic [PHASE_W-1:0]    SETUP_END = PHASE_W'(T_SETUP - 1);
  localparam logic [PHASE_W-1:0]    EH_END    = PHASE_W'(T_EH - 1);
  localparam logic [PHASE_W-1:0]    GAP_END   = PHASE_W'(T_GAP - 1);
  localparam logic [PHASE_W-1:0]    TURN_END  = PHASE_W'(T_TURN - 1);
  localparam logic [POLL_CNT_W-1:0] POLL_LIM  = POLL_CNT_W'(POLL_MAX);
  localparam logic [POLL_CNT_W-1:0] POLL_SAT  = '1;

  logic [3:0]            state;
  logic [3:0]            state_nxt;
  logic [PHASE_W-1:0]    phase;
  logic                  phase_done;
  logic [POLL_CNT_W-1:0] poll_cnt;
  logic                  poll_mode;
  logic                  rs_q;
  logic                  from_reset;
  logic [3:0]            nib_hi;
  logic [3:0]            nib_lo;
  logic                  accept;
  logic                  poll_expired;
  logic [7:0]            eval_byte;

  assign accept       = (state == ST_IDLE) && (rd_req || poll_req);
  assign eval_byte    = {nib_hi, nib_lo};
  assign poll_expired = poll_mode && nib_hi[3] && (poll_cnt >= POLL_LIM);

  // Phase end detect: the timer restarts at 0 on every state change, so a
  // phase of N cycles ends when the timer reaches N-1. One-cycle states
  // (REL, EVAL, HOLD) end on their first cycle.
  always_comb begin
    phase_done = 1'b1;
    case (state)
      ST_SETUP:        phase_done = (phase == SETUP_END);
      ST_EH1, ST_EH2:  phase_done = (phase == EH_END);
      ST_GAP1, ST_GAP2: phase_done = (phase == GAP_END);
      ST_TURN:         phase_done = (phase == TURN_END);
      default:         phase_done = 1'b1;
    endcase
  end

  // Next-state logic. A poll loops EVAL -> GAP2 -> EH1 ... until BF clears
  // or the poll budget is spent; a single read always goes straight to HOLD.
  // Unused encodings fall back to TURN so the bus is released safely.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)     state_nxt = ST_REL;
      ST_REL:                   state_nxt = ST_SETUP;
      ST_SETUP: if (phase_done) state_nxt = ST_EH1;
      ST_EH1:   if (phase_done) state_nxt = ST_GAP1;
      ST_GAP1:  if (phase_done) state_nxt = ST_EH2;
      ST_EH2:   if (phase_done) state_nxt = ST_EVAL;
      ST_EVAL: begin
        if (!poll_mode || !nib_hi[3] || poll_expired) state_nxt = ST_HOLD;
        else                                          state_nxt = ST_GAP2;
      end
      ST_GAP2:  if (phase_done) state_nxt = ST_EH1;
      ST_HOLD:                  state_nxt = ST_TURN;
      ST_TURN:  if (phase_done) state_nxt = ST_IDLE;
      default:                  state_nxt = ST_TURN;
    endcase
  end

  // State register and phase timer. Reset lands in TURN so the bus sits
  // released for the turnaround time before the engine reports idle. The
  // timer is parked at 0 in IDLE so it never wraps while waiting.
  always_ff @(posedge SYS_CLK_50M or posedge SYS_RST) begin
    if (SYS_RST) begin
      state <= ST_TURN;
      phase <= '0;
    end else begin
      state <= state_nxt;
      if ((state_nxt != state) || (state == ST_IDLE)) phase <= '0;
      else                                            phase <= phase + 1'b1;
    end
  end

  // Request capture. from_reset remembers that the current TURN came from
  // reset rather than from a transaction, so no done pulse is issued for it.
  // A poll always reads the instruction register, hence RS forced to 0.
  always_ff @(posedge SYS_CLK_50M or posedge SYS_RST) begin
    if (SYS_RST) begin
      from_reset <= 1'b1;
      poll_mode  <= 1'b0;
      rs_q       <= 1'b0;
    end else if (accept) begin
      from_reset <= 1'b0;
      poll_mode  <= poll_req;
      rs_q       <= poll_req ? 1'b0 : rd_rs;
    end
  end

  // Poll budget counter: cleared on accept, counts every busy cycle of a
  // poll and saturates instead of wrapping.
  always_ff @(posedge SYS_CLK_50M or posedge SYS_RST) begin
    if (SYS_RST) begin
      poll_cnt <= '0;
    end else if (accept) begin
      poll_cnt <= '0;
    end else if (poll_mode && (state != ST_IDLE) && (poll_cnt != POLL_SAT)) begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  // Nibble capture on the last cycle of each E-high phase, when the LCD
  // output has had the full strobe width to settle.
  always_ff @(posedge SYS_CLK_50M or posedge SYS_RST) begin
    if (SYS_RST) begin
      nib_hi <= '0;
      nib_lo <= '0;
    end else begin
      if ((state == ST_EH1) && phase_done) nib_hi <= LCD_DATA_IN;
      if ((state == ST_EH2) && phase_done) nib_lo <= LCD_DATA_IN;
    end
  end

  // Result registers, updated once per read in EVAL. bf/ac only track
  // instruction-register reads; a data read leaves them alone. timeout is
  // cleared when a new request is taken.
  always_ff @(posedge SYS_CLK_50M or posedge SYS_RST) begin
    if (SYS_RST) begin
      rd_data <= '0;
      bf      <= 1'b0;
      ac      <= '0;
      timeout <= 1'b0;
    end else begin
      if (accept) timeout <= 1'b0;
      if (state == ST_EVAL) begin
        rd_data <= eval_byte;
        if (!rs_q) begin
          bf <= eval_byte[7];
          ac <= eval_byte[6:0];
        end
        if (poll_expired) timeout <= 1'b1;
      end
    end
  end

  // Output decode straight from the registered state, so reset forces every
  // LCD line to its safe value immediately. The FPGA drives the data bus
  // only in IDLE, which is always reached through REL/TURN with RW low.
  always_comb begin
    busy       = (state != ST_IDLE);
    lcd_drv_en = (state == ST_IDLE);
    LCD_RW     = rw_active(state);
    LCD_RS     = rw_active(state) & rs_q;
    LCD_E      = (state == ST_EH1) || (state == ST_EH2);
    done       = (state == ST_TURN) && phase_done && !from_reset;
  end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// ---------------------------------------------------------------------------
// tb_lcd_bus_reader
//   Directed self-checking bench for lcd_bus_reader. A small LCD model
//   returns a programmed byte per E-pair (upper nibble on the first strobe,
//   lower on the second). A shorter poll budget keeps the timeout case short.
// ---------------------------------------------------------------------------
module tb_lcd_bus_reader;

  localparam int T_SETUP  = 2;
  localparam int T_EH     = 12;
  localparam int T_GAP    = 50;
  localparam int T_TURN   = 2;
  localparam int POLL_MAX = 1000;

  // Clock edges from the accepting edge to the sample where done is seen:
  // REL + SETUP + EH1 + GAP1 + EH2 + EVAL + HOLD + TURN
  localparam int SINGLE_LAT = 1 + T_SETUP + T_EH + T_GAP + T_EH + 1 + 1 + T_TURN;
  // Extra cycles per additional poll iteration: GAP2 + EH1 + GAP1 + EH2 + EVAL
  localparam int POLL_ITER  = T_GAP + T_EH + T_GAP + T_EH + 1;
  // Cycles with RW=1 in one single read: SETUP..HOLD
  localparam int RW_HIGH    = T_SETUP + T_EH + T_GAP + T_EH + 1 + 1;

  logic       SYS_CLK_50M;
  logic       SYS_RST;
  logic       rd_req;
  logic       rd_rs;
  logic       poll_req;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       bf;
  logic [6:0] ac;
  logic       timeout;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_E;
  logic [3:0] LCD_DATA_IN;
  logic       lcd_drv_en;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] rsp [4];
  logic [7:0] cur_rsp;
  logic       nib_sel;
  logic [7:0] pair_cnt;
  logic       model_clear;

  int   e_run;
  int   rw_low_run;
  logic prev_drv;

  lcd_bus_reader #(
    .T_SETUP (T_SETUP),
    .T_EH    (T_EH),
    .T_GAP   (T_GAP),
    .T_TURN  (T_TURN),
    .POLL_MAX(POLL_MAX)
  ) dut (
    .SYS_CLK_50M(SYS_CLK_50M),
    .SYS_RST    (SYS_RST),
    .rd_req     (rd_req),
    .rd_rs      (rd_rs),
    .poll_req   (poll_req),
    .busy       (busy),
    .done       (done),
    .rd_data    (rd_data),
    .bf         (bf),
    .ac         (ac),
    .timeout    (timeout),
    .LCD_RS     (LCD_RS),
    .LCD_RW     (LCD_RW),
    .LCD_E      (LCD_E),
    .LCD_DATA_IN(LCD_DATA_IN),
    .lcd_drv_en (lcd_drv_en)
  );

  // 50 MHz clock
  initial SYS_CLK_50M = 1'b0;
  always #10 SYS_CLK_50M = ~SYS_CLK_50M;

  // LCD model: each E falling edge advances the nibble; a completed pair
  // advances to the next programmed response (the last one repeats).
  always @(negedge LCD_E or posedge model_clear) begin
    if (model_clear) begin
      nib_sel  <= 1'b0;
      pair_cnt <= '0;
    end else if (nib_sel) begin
      nib_sel  <= 1'b0;
      pair_cnt <= pair_cnt + 1'b1;
    end else begin
      nib_sel  <= 1'b1;
    end
  end

  assign cur_rsp     = (pair_cnt >= 8'd3) ? rsp[3] : rsp[pair_cnt[1:0]];
  assign LCD_DATA_IN = nib_sel ? cur_rsp[3:0] : cur_rsp[7:4];

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic req_rd, input logic rs,
                               input logic req_poll);
    @(posedge SYS_CLK_50M);
    #1;
    rd_req   = req_rd;
    rd_rs    = rs;
    poll_req = req_poll;
    @(posedge SYS_CLK_50M);
    #1;
    rd_req   = 1'b0;
    poll_req = 1'b0;
  endtask

  task automatic setResponses(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
    rsp[0] = a;
    rsp[1] = b;
    rsp[2] = c;
    rsp[3] = d;
    model_clear = 1'b1;
    #1;
    model_clear = 1'b0;
  endtask

  task automatic waitDone(input int limit, output int cycles,
                          output int rw_cycles, output int rs_cycles,
                          output logic seen);
    cycles    = 0;
    rw_cycles = 0;
    rs_cycles = 0;
    seen      = 1'b0;
    while ((cycles < limit) && !seen) begin
      @(negedge SYS_CLK_50M);
      cycles++;
      if (LCD_RW) rw_cycles++;
      if (LCD_RS) rs_cycles++;
      if (done)   seen = 1'b1;
    end
  endtask

  // Continuous bus checks on every falling edge: no drive while the LCD is
  // in read mode, drive only after the turnaround time, and every complete
  // E strobe exactly T_EH cycles wide (strobes cut by reset are dropped).
  always @(negedge SYS_CLK_50M) begin
    if (LCD_RW) begin
      checkOutput("no_contention", {31'd0, lcd_drv_en}, 32'd0);
      rw_low_run = 0;
    end else begin
      rw_low_run = rw_low_run + 1;
    end
    if (lcd_drv_en && !prev_drv)
      checkOutput("turnaround", {31'd0, rw_low_run > T_TURN}, 32'd1);
    prev_drv = lcd_drv_en;
    if (SYS_RST) begin
      e_run = 0;
    end else if (LCD_E) begin
      e_run = e_run + 1;
    end else if (e_run != 0) begin
      checkOutput("e_width", e_run, T_EH);
      e_run = 0;
    end
  end

  // Watchdog so a stuck design still ends the run
  initial begin
    #(20 * 40000);
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   cyc;
    int   rwc;
    int   rsc;
    int   cnt;
    logic seen;
    logic found;

    e_run       = 0;
    rw_low_run  = 0;
    prev_drv    = 1'b0;
    SYS_RST     = 1'b1;
    rd_req      = 1'b0;
    rd_rs       = 1'b0;
    poll_req    = 1'b0;
    model_clear = 1'b0;
    setResponses(8'h00, 8'h00, 8'h00, 8'h00);

    // Test 1: reset values, then T_TURN busy cycles and silent return to idle
    repeat (3) @(posedge SYS_CLK_50M);
    @(negedge SYS_CLK_50M);
    checkOutput("rst_busy",    {31'd0, busy},       32'd1);
    checkOutput("rst_done",    {31'd0, done},       32'd0);
    checkOutput("rst_rd_data", {24'd0, rd_data},    32'h00);
    checkOutput("rst_bf",      {31'd0, bf},         32'd0);
    checkOutput("rst_ac",      {25'd0, ac},         32'd0);
    checkOutput("rst_timeout", {31'd0, timeout},    32'd0);
    checkOutput("rst_rs",      {31'd0, LCD_RS},     32'd0);
    checkOutput("rst_rw",      {31'd0, LCD_RW},     32'd0);
    checkOutput("rst_e",       {31'd0, LCD_E},      32'd0);
    checkOutput("rst_drv",     {31'd0, lcd_drv_en}, 32'd0);
    @(posedge SYS_CLK_50M);
    #1;
    SYS_RST = 1'b0;
    for (int i = 0; i < T_TURN; i++) begin
      @(negedge SYS_CLK_50M);
      checkOutput("rel_busy", {31'd0, busy}, 32'd1);
      checkOutput("rel_done", {31'd0, done}, 32'd0);
    end
    @(negedge SYS_CLK_50M);
    checkOutput("idle_busy", {31'd0, busy},       32'd0);
    checkOutput("idle_drv",  {31'd0, lcd_drv_en}, 32'd1);
    checkOutput("idle_done", {31'd0, done},       32'd0);

    // Test 2: single data read returning 0x41
    $display("[TB] single read RS=1");
    setResponses(8'h41, 8'h41, 8'h41, 8'h41);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitDone(300, cyc, rwc, rsc, seen);
    checkOutput("t2_done_seen", {31'd0, seen},    32'd1);
    checkOutput("t2_latency",   cyc,              SINGLE_LAT);
    checkOutput("t2_rw_cycles", rwc,              RW_HIGH);
    checkOutput("t2_rs_cycles", rsc,              RW_HIGH);
    checkOutput("t2_rd_data",   {24'd0, rd_data}, 32'h41);
    checkOutput("t2_bf",        {31'd0, bf},      32'd0);
    checkOutput("t2_ac",        {25'd0, ac},      32'd0);
    checkOutput("t2_timeout",   {31'd0, timeout}, 32'd0);
    checkOutput("t2_pairs",     {24'd0, pair_cnt}, 32'd1);
    @(negedge SYS_CLK_50M);
    checkOutput("t2_done_pulse", {31'd0, done}, 32'd0);
    checkOutput("t2_idle",       {31'd0, busy}, 32'd0);

    // Test 3: poll sees BF=1 three times, then 0x05
    $display("[TB] poll until ready");
    setResponses(8'h80, 8'h8A, 8'h9F, 8'h05);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitDone(3000, cyc, rwc, rsc, seen);
    checkOutput("t3_done_seen", {31'd0, seen},     32'd1);
    checkOutput("t3_latency",   cyc,               SINGLE_LAT + 3 * POLL_ITER);
    checkOutput("t3_pairs",     {24'd0, pair_cnt}, 32'd4);
    checkOutput("t3_rs_cycles", rsc,               32'd0);
    checkOutput("t3_rd_data",   {24'd0, rd_data},  32'h05);
    checkOutput("t3_bf",        {31'd0, bf},       32'd0);
    checkOutput("t3_ac",        {25'd0, ac},       32'h05);
    checkOutput("t3_timeout",   {31'd0, timeout},  32'd0);

    // Test 4: BF stuck high. Poll counter at EVAL k is 77 + 125*(k-1), so the
    // budget of 1000 is first reached on the 9th read.
    $display("[TB] poll timeout");
    setResponses(8'h80, 8'h80, 8'h80, 8'h80);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitDone(5000, cyc, rwc, rsc, seen);
    checkOutput("t4_done_seen", {31'd0, seen},            32'd1);
    checkOutput("t4_min_time",  {31'd0, cyc >= POLL_MAX}, 32'd1);
    checkOutput("t4_latency",   cyc,                      SINGLE_LAT + 8 * POLL_ITER);
    checkOutput("t4_pairs",     {24'd0, pair_cnt},        32'd9);
    checkOutput("t4_timeout",   {31'd0, timeout},         32'd1);
    checkOutput("t4_rd_data",   {24'd0, rd_data},         32'h80);
    checkOutput("t4_bf",        {31'd0, bf},              32'd1);
    checkOutput("t4_ac",        {25'd0, ac},              32'd0);

    // Test 5: simultaneous requests, then a request while busy
    $display("[TB] request priority and busy drop");
    setResponses(8'h12, 8'h12, 8'h12, 8'h12);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t5_timeout_clr", {31'd0, timeout}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitDone(300, cyc, rwc, rsc, seen);
    checkOutput("t5_done_seen", {31'd0, seen},     32'd1);
    checkOutput("t5_latency",   cyc,               SINGLE_LAT - 2);
    checkOutput("t5_rs_cycles", rsc,               32'd0);
    checkOutput("t5_pairs",     {24'd0, pair_cnt}, 32'd1);
    checkOutput("t5_rd_data",   {24'd0, rd_data},  32'h12);
    checkOutput("t5_ac",        {25'd0, ac},       32'h12);
    cnt = 0;
    repeat (10) begin
      @(negedge SYS_CLK_50M);
      if (busy) cnt++;
    end
    checkOutput("t5_no_queue", cnt, 32'd0);

    // Test 6: reset in the middle of the second strobe
    $display("[TB] reset during EH2");
    setResponses(8'h3C, 8'h3C, 8'h3C, 8'h3C);
    applyStimulus(1'b1, 1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; (i < 200) && !found; i++) begin
      @(negedge SYS_CLK_50M);
      if (LCD_E && nib_sel) found = 1'b1;
    end
    checkOutput("t6_eh2_reached", {31'd0, found}, 32'd1);
    repeat (3) @(negedge SYS_CLK_50M);
    #2;
    SYS_RST = 1'b1;
    #1;
    checkOutput("t6_e",       {31'd0, LCD_E},      32'd0);
    checkOutput("t6_rw",      {31'd0, LCD_RW},     32'd0);
    checkOutput("t6_drv",     {31'd0, lcd_drv_en}, 32'd0);
    checkOutput("t6_busy",    {31'd0, busy},       32'd1);
    checkOutput("t6_rd_data", {24'd0, rd_data},    32'h00);
    checkOutput("t6_ac",      {25'd0, ac},         32'h00);
    repeat (2) @(posedge SYS_CLK_50M);
    #1;
    SYS_RST = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge SYS_CLK_50M);
      if (done) cnt++;
    end
    checkOutput("t6_no_done", cnt,                32'd0);
    checkOutput("t6_idle",    {31'd0, busy},      32'd0);
    setResponses(8'h7E, 8'h7E, 8'h7E, 8'h7E);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitDone(300, cyc, rwc, rsc, seen);
    checkOutput("t6_done_seen", {31'd0, seen},    32'd1);
    checkOutput("t6_latency",   cyc,              SINGLE_LAT);
    checkOutput("t6_rd_data2",  {24'd0, rd_data}, 32'h7E);

    repeat (4) @(negedge SYS_CLK_50M);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
